wgt_fifo_ctrl: RTL and testbench
================================

Name: wgt_fifo_ctrl

Overview:
Sequencer for the 16-lane weight FIFO array. It clears the FIFOs, loads one weight tile from the weight buffer through a valid/ready handshake, and drives per-lane read enables with a one-cycle-per-lane diagonal skew to feed the systolic array. Between output passes it rewinds the read pointers so the same tile can be replayed cfg_num_pass times. It sits between the layer controller, the weight buffer and wgt_FIFO_array.

Parameters:
NUM_FIFO, 16, number of FIFO lanes (filters per tile)
MAX_WGT_FIFO_SIZE, 4608, FIFO depth in words
LEN_WIDTH, 13, width of word counters (ceil log2(MAX_WGT_FIFO_SIZE+1))
PASS_WIDTH, 8, width of pass counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_start  in  1  start pulse; config sampled this cycle; ignored while busy
cfg_num_filter  in  5  active lanes, 1..16
cfg_wgt_len  in  LEN_WIDTH  words per FIFO, 0..MAX_WGT_FIFO_SIZE
cfg_num_pass  in  PASS_WIDTH  replay count
wgt_valid  in  1  weight buffer has a NUM_FIFO-wide word
wgt_ready  out  1  controller accepts word
compute_ready  in  1  array ready to start a pass
wr_clr  out  1  FIFO write-pointer clear
rd_clr  out  1  FIFO read-pointer clear/rewind (data retained)
wr_en  out  1  FIFO write enable
rd_en  out  NUM_FIFO  per-lane read enable
read_wgt_size  out  5  latched lane count to FIFO array
pass_done  out  1  one-cycle pulse, pass complete
done  out  1  one-cycle pulse, tile complete
busy  out  1  high from accepted start until done

Behaviour:
- Reset: state IDLE; wgt_ready, wr_clr, rd_clr, wr_en, pass_done, done, busy = 0; rd_en = 0; read_wgt_size = 16; all counters 0.
- Config clamp at latch: num_filter 0 or >16 -> 16; num_pass 0 -> 1; wgt_len > MAX_WGT_FIFO_SIZE -> MAX_WGT_FIFO_SIZE.
- States: IDLE, CLEAR, LOAD, WAIT_PASS, READ, DRAIN, REWIND, DONE.
- IDLE: cfg_start -> latch config, busy=1 next cycle, -> CLEAR.
- CLEAR: wr_clr=1, rd_clr=1 for exactly one cycle. If len==0 -> DONE, otherwise -> LOAD.
- LOAD: wgt_ready=1 (registered, high every LOAD cycle). wr_en = wgt_valid & wgt_ready (combinational, same cycle as handshake). wr_cnt increments per accept. Accept with wr_cnt==len-1 -> WAIT_PASS; wgt_ready low from the next cycle. wgt_valid gaps stall without loss.
- WAIT_PASS: all rd_en 0. compute_ready high at edge k -> READ.
- READ: base enable b=1 for len cycles, k+1..k+len. rd_en is a registered shift chain: rd_en[0]=b, rd_en[i] = rd_en[i-1] delayed one cycle. Lane i is high on cycles k+1+i..k+len+i. Lanes i >= num_filter are forced 0. After len cycles -> DRAIN.
- DRAIN: b=0 until the chain is empty. Last enable is on lane num_filter-1 at cycle k+len+num_filter-1. pass_done pulses the cycle after the chain is empty.
- On pass_done: if pass_cnt==num_pass-1 -> DONE, else pass_cnt++ -> REWIND.
- REWIND: rd_clr=1 for one cycle -> WAIT_PASS.
- DONE: done=1 one cycle, busy=0 next cycle, -> IDLE.
- compute_ready is sampled only in WAIT_PASS. cfg_start is ignored in any state other than IDLE.
- rst asserted mid-operation: every output returns to its reset value the next cycle. No clear pulse is issued; the next start issues CLEAR.
- Simultaneous cfg_start and done in the same cycle: start is ignored; state is not IDLE until the following cycle.
- The controller never writes more than len words, so the FIFOs never overflow. The read count equals the write count per pass, so no underflow.

Test Plan:
- Basic: num_filter=16, len=4, pass=1, wgt_valid held high -> wr_clr and rd_clr one pulse; wr_en 4 cycles; compute_ready at k; rd_en[0] high k+1..k+4, rd_en[15] high k+16..k+19; pass_done at k+20; done next cycle.
- Partial lanes: num_filter=3, len=2 -> read_wgt_size=3; rd_en[15:3] never high; rd_en[2] high k+3..k+4.
- Backpressure: len=5, wgt_valid toggling 1,0,1,1,0,0,1,1 -> exactly 5 wr_en, coincident with valid; wgt_ready drops after the 5th accept.
- Replay: len=3, num_pass=3, nf=16 -> 3 pass_done pulses; rd_clr pulse after passes 1 and 2 only; one done; each pass waits for compute_ready.
- Edge config: len=0 -> CLEAR then done with no wr_en/rd_en; num_filter=0, num_pass=0 -> behaves as 16 lanes and 1 pass.
- rst mid-READ, then a new start -> outputs at reset values the next cycle; the new start performs a full CLEAR/LOAD sequence.

Source files
------------

// File: rtl/wgt_fifo_ctrl.sv
// Weight FIFO sequencer. Clears the FIFOs, loads one tile, then replays it
// cfg_num_pass times with a one-cycle-per-lane diagonal read skew.

module wgt_fifo_lane (
  input  logic clk,
  input  logic rst,
  input  logic prev_i,
  input  logic act_i,
  output logic en_d_o,
  output logic en_q_o
);
  assign en_d_o = prev_i & act_i;

  always_ff @(posedge clk) begin
    if (rst) en_q_o <= 1'b0;
    else     en_q_o <= en_d_o;
  end
endmodule

module wgt_fifo_ctrl #(
  parameter int NUM_FIFO          = 16,
  parameter int MAX_WGT_FIFO_SIZE = 4608,
  parameter int LEN_WIDTH         = 13,
  parameter int PASS_WIDTH        = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic [4:0]            cfg_num_filter,
  input  logic [LEN_WIDTH-1:0]  cfg_wgt_len,
  input  logic [PASS_WIDTH-1:0] cfg_num_pass,
  input  logic                  wgt_valid,
  output logic                  wgt_ready,
  input  logic                  compute_ready,
  output logic                  wr_clr,
  output logic                  rd_clr,
  output logic                  wr_en,
  output logic [NUM_FIFO-1:0]   rd_en,
  output logic [4:0]            read_wgt_size,
  output logic                  pass_done,
  output logic                  done,
  output logic                  busy
);
  typedef enum logic [2:0] {
    IDLE, CLEAR, LOAD, WAIT_PASS, READ, DRAIN, REWIND, DONE
  } state_e;

  state_e                state_q;
  logic [4:0]            nf_q;
  logic [LEN_WIDTH-1:0]  len_q, wr_cnt_q, rd_cnt_q;
  logic [PASS_WIDTH-1:0] npass_q, pass_cnt_q;
  logic                  wgt_ready_q, wr_clr_q, rd_clr_q, pass_done_q, done_q, busy_q;
  logic [NUM_FIFO-1:0]   rd_en_q, rd_en_d, lane_act;
  logic [NUM_FIFO:0]     chain;
  logic                  base_d;

  // Base enable feeding lane 0; each later lane is lane-1 delayed one cycle.
  assign base_d = (state_q == WAIT_PASS && compute_ready) ||
                  (state_q == READ && rd_cnt_q != len_q);
  assign chain  = {rd_en_q, base_d};

  for (genvar g = 0; g < NUM_FIFO; g++) begin : g_lane
    localparam logic [4:0] LANE = 5'(g);
    assign lane_act[g] = (LANE < nf_q);
    wgt_fifo_lane u_lane (
      .clk    (clk),
      .rst    (rst),
      .prev_i (chain[g]),
      .act_i  (lane_act[g]),
      .en_d_o (rd_en_d[g]),
      .en_q_o (rd_en_q[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      nf_q        <= 5'(NUM_FIFO);
      len_q       <= '0;
      npass_q     <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      pass_cnt_q  <= '0;
      wgt_ready_q <= 1'b0;
      wr_clr_q    <= 1'b0;
      rd_clr_q    <= 1'b0;
      pass_done_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      wr_clr_q    <= 1'b0;
      rd_clr_q    <= 1'b0;
      pass_done_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: if (cfg_start) begin
          nf_q       <= (cfg_num_filter == '0 || cfg_num_filter > 5'(NUM_FIFO))
                        ? 5'(NUM_FIFO) : cfg_num_filter;
          len_q      <= (cfg_wgt_len > LEN_WIDTH'(MAX_WGT_FIFO_SIZE))
                        ? LEN_WIDTH'(MAX_WGT_FIFO_SIZE) : cfg_wgt_len;
          npass_q    <= (cfg_num_pass == '0) ? PASS_WIDTH'(1) : cfg_num_pass;
          wr_cnt_q   <= '0;
          pass_cnt_q <= '0;
          busy_q     <= 1'b1;
          wr_clr_q   <= 1'b1;
          rd_clr_q   <= 1'b1;
          state_q    <= CLEAR;
        end
        CLEAR: if (len_q == '0) begin
          done_q  <= 1'b1;
          state_q <= DONE;
        end else begin
          wgt_ready_q <= 1'b1;
          state_q     <= LOAD;
        end
        LOAD: if (wgt_valid) begin
          wr_cnt_q <= wr_cnt_q + LEN_WIDTH'(1);
          if (wr_cnt_q == len_q - LEN_WIDTH'(1)) begin
            wgt_ready_q <= 1'b0;
            state_q     <= WAIT_PASS;
          end
        end
        WAIT_PASS: if (compute_ready) begin
          rd_cnt_q <= LEN_WIDTH'(1);
          state_q  <= READ;
        end
        READ: if (rd_cnt_q != len_q) begin
          rd_cnt_q <= rd_cnt_q + LEN_WIDTH'(1);
        end else begin
          // With a single lane the chain is already empty on the last base cycle.
          if (rd_en_d == '0) pass_done_q <= 1'b1;
          state_q <= DRAIN;
        end
        DRAIN: if (pass_done_q) begin
          if (pass_cnt_q == npass_q - PASS_WIDTH'(1)) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            pass_cnt_q <= pass_cnt_q + PASS_WIDTH'(1);
            rd_clr_q   <= 1'b1;
            state_q    <= REWIND;
          end
        end else if (rd_en_d == '0) begin
          pass_done_q <= 1'b1;
        end
        REWIND: state_q <= WAIT_PASS;
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wgt_ready     = wgt_ready_q;
  assign wr_en         = wgt_valid & wgt_ready_q;
  assign wr_clr        = wr_clr_q;
  assign rd_clr        = rd_clr_q;
  assign rd_en         = rd_en_q;
  assign read_wgt_size = nf_q;
  assign pass_done     = pass_done_q;
  assign done          = done_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_wgt_fifo_ctrl.sv
// Directed bench for wgt_fifo_ctrl: a negedge monitor tallies events per test,
// and hand-computed timings are compared against those tallies.

module tb_wgt_fifo_ctrl;
  localparam int NF = 16;

  logic        clk = 1'b0;
  logic        rst, cfg_start, wgt_valid, compute_ready;
  logic [4:0]  cfg_num_filter;
  logic [12:0] cfg_wgt_len;
  logic [7:0]  cfg_num_pass;
  logic        wgt_ready, wr_clr, rd_clr, wr_en, pass_done, done, busy;
  logic [NF-1:0] rd_en;
  logic [4:0]  read_wgt_size;

  wgt_fifo_ctrl dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_num_filter(cfg_num_filter),
    .cfg_wgt_len(cfg_wgt_len), .cfg_num_pass(cfg_num_pass), .wgt_valid(wgt_valid),
    .wgt_ready(wgt_ready), .compute_ready(compute_ready), .wr_clr(wr_clr),
    .rd_clr(rd_clr), .wr_en(wr_en), .rd_en(rd_en), .read_wgt_size(read_wgt_size),
    .pass_done(pass_done), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  logic stat_clr = 1'b0;
  int n_wr, n_wr_bad, n_rdy, n_wclr, n_rclr, n_pd, n_done;
  int t_wclr, t_rclr, t_pd, t_done;
  int n_on[NF], t_first[NF], t_last[NF];

  // Event tally, sampled mid-cycle; cyc is the number of edges seen so far.
  always @(negedge clk) begin
    if (stat_clr) begin
      n_wr = 0; n_wr_bad = 0; n_rdy = 0; n_wclr = 0; n_rclr = 0; n_pd = 0; n_done = 0;
      t_wclr = -1; t_rclr = -1; t_pd = -1; t_done = -1;
      for (int i = 0; i < NF; i++) begin n_on[i] = 0; t_first[i] = -1; t_last[i] = -1; end
    end else begin
      if (wr_en) n_wr++;
      if (wr_en && !(wgt_valid && wgt_ready)) n_wr_bad++;
      if (wgt_ready) n_rdy++;
      if (wr_clr) begin n_wclr++; t_wclr = cyc; end
      if (rd_clr) begin n_rclr++; t_rclr = cyc; end
      if (pass_done) begin n_pd++; t_pd = cyc; end
      if (done) begin n_done++; t_done = cyc; end
      for (int i = 0; i < NF; i++) if (rd_en[i]) begin
        if (n_on[i] == 0) t_first[i] = cyc;
        t_last[i] = cyc;
        n_on[i]++;
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clr_stats();
    stat_clr = 1'b1;
    @(negedge clk); #1;
    stat_clr = 1'b0;
  endtask

  // Returns s = edge that sampled the start; exits in the first LOAD cycle.
  task automatic start(input int nf, input int len, input int np, output int s);
    cfg_num_filter = 5'(nf);
    cfg_wgt_len    = 13'(len);
    cfg_num_pass   = 8'(np);
    cfg_start      = 1'b1;
    @(posedge clk); #1;
    s = cyc;
    cfg_start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic load(input int nwr, input logic [7:0] pat);
    int idx = 0;
    while (n_wr < nwr && idx < nwr + 64) begin
      wgt_valid = pat[idx % 8];
      @(posedge clk); #1;
      idx++;
    end
    wgt_valid = 1'b0;
    if (n_wr < nwr) chk("tmo_load", n_wr, nwr);
  endtask

  // k = edge at which compute_ready is sampled.
  task automatic pulse_cr(output int k);
    compute_ready = 1'b1;
    k = cyc + 1;
    @(posedge clk); #1;
    compute_ready = 1'b0;
  endtask

  task automatic wait_pd(input int target, input int lim);
    int n = 0;
    while (n_pd < target && n < lim) begin @(posedge clk); #1; n++; end
    if (n_pd < target) chk("tmo_pass_done", n_pd, target);
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while (n_done == 0 && n < lim) begin @(posedge clk); #1; n++; end
    if (n_done == 0) chk("tmo_done", n_done, 1);
  endtask

  initial begin
    int s, k, tpd, sum;
    rst = 1'b1; cfg_start = 1'b0; wgt_valid = 1'b0; compute_ready = 1'b0;
    cfg_num_filter = '0; cfg_wgt_len = '0; cfg_num_pass = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(wgt_ready), 0);
    chk("rst_rden", int'(rd_en), 0);
    chk("rst_size", int'(read_wgt_size), 16);
    chk("rst_clr", int'(wr_clr | rd_clr), 0);
    chk("rst_pulses", int'(pass_done | done), 0);
    rst = 1'b0;
    idle(2);

    // basic: 16 lanes, len 4, one pass
    clr_stats();
    start(16, 4, 1, s);
    chk("basic_busy_on", int'(busy), 1);
    load(4, 8'hFF);
    idle(2);
    pulse_cr(k);
    wait_pd(1, 60);
    wait_done(10);
    chk("basic_wclr_n", n_wclr, 1);
    chk("basic_rclr_n", n_rclr, 1);
    chk("basic_wclr_t", t_wclr, s);
    chk("basic_wr_n", n_wr, 4);
    chk("basic_rdy_n", n_rdy, 4);
    chk("basic_l0_first", t_first[0], k);
    chk("basic_l0_last", t_last[0], k + 3);
    chk("basic_l15_first", t_first[15], k + 15);
    chk("basic_l15_last", t_last[15], k + 18);
    chk("basic_l15_n", n_on[15], 4);
    chk("basic_pd_t", t_pd, k + 19);
    chk("basic_done_t", t_done, k + 20);
    chk("basic_busy_off", int'(busy), 0);

    // partial lanes: nf 3, len 2
    clr_stats();
    start(3, 2, 1, s);
    load(2, 8'hFF);
    idle(2);
    pulse_cr(k);
    wait_pd(1, 40);
    wait_done(10);
    sum = 0;
    for (int i = 3; i < NF; i++) sum += n_on[i];
    chk("part_size", int'(read_wgt_size), 3);
    chk("part_hi_lanes", sum, 0);
    chk("part_l2_first", t_first[2], k + 2);
    chk("part_l2_last", t_last[2], k + 3);
    chk("part_pd_t", t_pd, k + 4);

    // backpressure: valid 1,0,1,1,0,0,1,1 then held high
    clr_stats();
    start(16, 5, 1, s);
    load(5, 8'b1100_1101);
    wgt_valid = 1'b1;
    idle(3);
    wgt_valid = 1'b0;
    chk("bp_wr_n", n_wr, 5);
    chk("bp_wr_bad", n_wr_bad, 0);
    chk("bp_rdy_n", n_rdy, 8);
    idle(2);
    pulse_cr(k);
    wait_pd(1, 60);
    wait_done(10);
    chk("bp_l0_n", n_on[0], 5);

    // replay: len 3, three passes, each gated by compute_ready
    clr_stats();
    start(16, 3, 3, s);
    load(3, 8'hFF);
    tpd = 0;
    for (int p = 0; p < 3; p++) begin
      idle(4);
      chk("rp_hold", n_on[0], 3 * p);
      if (p > 0) chk("rp_rewind_t", t_rclr, tpd + 1);
      pulse_cr(k);
      wait_pd(p + 1, 60);
      tpd = t_pd;
    end
    wait_done(10);
    chk("rp_pd_n", n_pd, 3);
    chk("rp_rclr_n", n_rclr, 3);
    chk("rp_done_n", n_done, 1);
    chk("rp_l15_n", n_on[15], 9);
    chk("rp_done_t", t_done, tpd + 1);

    // len 0, plus a start coincident with done
    clr_stats();
    start(16, 0, 1, s);
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    idle(3);
    chk("z_done_n", n_done, 1);
    chk("z_done_t", t_done, s + 1);
    chk("z_wr_n", n_wr, 0);
    chk("z_rdy_n", n_rdy, 0);
    chk("z_l0_n", n_on[0], 0);
    chk("z_wclr_n", n_wclr, 1);
    chk("z_busy", int'(busy), 0);

    // num_filter 0 and num_pass 0 clamp to 16 lanes, 1 pass
    clr_stats();
    start(0, 2, 0, s);
    load(2, 8'hFF);
    idle(2);
    pulse_cr(k);
    wait_pd(1, 40);
    wait_done(10);
    chk("c0_size", int'(read_wgt_size), 16);
    chk("c0_l15_n", n_on[15], 2);
    chk("c0_pd_n", n_pd, 1);

    // num_filter above 16 clamps to 16; len 1
    clr_stats();
    start(20, 1, 1, s);
    load(1, 8'hFF);
    idle(2);
    pulse_cr(k);
    wait_pd(1, 40);
    wait_done(10);
    chk("c20_size", int'(read_wgt_size), 16);
    chk("c20_l15_t", t_first[15], k + 15);
    chk("c20_pd_t", t_pd, k + 16);

    // oversize length clamps to FIFO depth
    clr_stats();
    start(16, 8191, 1, s);
    load(4608, 8'hFF);
    wgt_valid = 1'b1;
    idle(3);
    wgt_valid = 1'b0;
    chk("cl_wr_n", n_wr, 4608);
    idle(2);
    pulse_cr(k);
    wait_pd(1, 4700);
    wait_done(10);
    chk("cl_l0_n", n_on[0], 4608);

    // reset during READ, then a fresh tile
    clr_stats();
    start(5, 8, 1, s);
    load(8, 8'hFF);
    idle(2);
    pulse_cr(k);
    idle(3);
    chk("mr_pre_rden", int'(rd_en != '0), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mr_rden", int'(rd_en), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_size", int'(read_wgt_size), 16);
    chk("mr_ready", int'(wgt_ready | wr_en), 0);
    chk("mr_clr", int'(wr_clr | rd_clr), 0);
    chk("mr_pulses", int'(pass_done | done), 0);
    rst = 1'b0;
    clr_stats();
    idle(3);
    chk("mr_noclr", n_wclr + n_rclr, 0);
    start(16, 4, 1, s);
    load(4, 8'hFF);
    idle(2);
    pulse_cr(k);
    wait_pd(1, 60);
    wait_done(10);
    chk("mr_wclr_n", n_wclr, 1);
    chk("mr_wclr_t", t_wclr, s);
    chk("mr_wr_n", n_wr, 4);
    chk("mr_pd_t", t_pd, k + 19);
    chk("mr_done_n", n_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
